// File: rtl/debug_pkg.sv
// Shared opcodes, response codes, control bit positions and FSM states for the debug controller.
package debug_pkg;

  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RESUME = 8'h02;
  localparam logic [7:0] OP_RDREG  = 8'h10;
  localparam logic [7:0] OP_WRREG  = 8'h11;
  localparam logic [7:0] OP_RDCSR  = 8'h20;

  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  localparam int CTRL_WR   = 0;
  localparam int CTRL_ACT  = 1;
  localparam int CTRL_HALT = 2;
  localparam int CTRL_CSR  = 3;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_ISSUE,
    ST_SAMPLE,
    ST_SEND,
    ST_ACK
  } state_t;

endpackage

// File: rtl/debug_byte_shifter.sv
// Little-endian byte shift register with parallel load, shared by write assembly and read serialisation.
// Latency: load/shift take effect on the next clock edge.
// Backpressure: none internally; the caller only asserts shift_vld on an accepted byte.
module debug_byte_shifter
  import debug_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load_vld,
  input  logic [N-1:0] load_dat,
  input  logic         shift_vld,
  input  logic [7:0]   shift_dat,
  output logic [N-1:0] sr_dat,
  output logic [7:0]   byte_dat,
  output logic         last
);

  localparam int NB = N / 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

  logic [CNT_W-1:0] cnt;

  // Bytes enter at the top and leave from the bottom, so the first byte ends up as the LSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_dat <= '0;
      cnt    <= '0;
    end else if (load_vld) begin
      sr_dat <= load_dat;
      cnt    <= '0;
    end else if (shift_vld) begin
      sr_dat <= (sr_dat >> 8) | (N'(shift_dat) << (N - 8));
      cnt    <= cnt + 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

  assign byte_dat = sr_dat[7:0];
  assign last     = (cnt == LAST_IDX);

endmodule

// File: rtl/debug_controller.sv
// Host-byte-stream debug initiator driving the core coprocessor IO port (halt/resume, reg rd/wr, CSR rd).
// Latency: last command byte -> ISSUE next cycle -> first response byte 2 cycles later.
// Backpressure: rx_ready only while collecting a command; response bytes held until tx_ready.
module debug_controller
  import debug_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [14:0]  coprocessorIOAddr,
  output logic [4:0]   coprocessorIOControl,
  output logic [N-1:0] coprocessorIODataOut,
  input  logic [N-1:0] coprocessorIODataIn,
  output logic         halted
);

  state_t state, state_nxt;

  logic [7:0]   op_q;
  logic [7:0]   rsp_q;
  logic [11:0]  addr_q;
  logic         addr_hi_q;
  logic [N-1:0] wdat_q;
  logic         halted_q;

  logic         accept;
  logic         rx_fire;
  logic         sh_clr, sh_load, sh_shift, sh_last;
  logic [7:0]   sh_in, sh_byte;
  logic [N-1:0] sh_dat;

  assign accept   = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign rx_fire  = accept && rx_valid;
  // Held low while reset is asserted so every output reads 0 during reset.
  assign rx_ready = accept && reset;

  debug_byte_shifter #(.N(N)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clr       (sh_clr),
    .load_vld  (sh_load),
    .load_dat  (coprocessorIODataIn),
    .shift_vld (sh_shift),
    .shift_dat (sh_in),
    .sr_dat    (sh_dat),
    .byte_dat  (sh_byte),
    .last      (sh_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    tx_valid             = 1'b0;
    tx_data              = 8'h00;
    coprocessorIOControl = '0;
    coprocessorIOAddr    = '0;
    sh_clr               = 1'b0;
    sh_load              = 1'b0;
    sh_shift             = 1'b0;
    sh_in                = 8'h00;
    coprocessorIOControl[CTRL_HALT] = halted_q;
    unique case (state)
      ST_IDLE: begin
        sh_clr = 1'b1;
        if (rx_fire) begin
          if (rx_data == OP_RDREG || rx_data == OP_WRREG || rx_data == OP_RDCSR)
            state_nxt = ST_GET_ADDR;
          else
            state_nxt = ST_ACK;
        end
      end
      ST_GET_ADDR: begin
        if (rx_fire) begin
          if (op_q == OP_RDCSR && !addr_hi_q) state_nxt = ST_GET_ADDR;
          else if (op_q == OP_WRREG)          state_nxt = ST_GET_DATA;
          else                                state_nxt = ST_ISSUE;
        end
      end
      ST_GET_DATA: begin
        if (rx_fire) begin
          sh_shift = 1'b1;
          sh_in    = rx_data;
          if (sh_last) state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_SAMPLE: begin
        coprocessorIOControl[CTRL_ACT] = 1'b1;
        coprocessorIOControl[CTRL_CSR] = (op_q == OP_RDCSR);
        coprocessorIOAddr = (op_q == OP_RDCSR) ? {3'b000, addr_q} : {10'b0, addr_q[4:0]};
        if (state == ST_ISSUE) begin
          coprocessorIOControl[CTRL_WR] = (op_q == OP_WRREG);
          state_nxt = ST_SAMPLE;
        end else begin
          sh_load   = (op_q != OP_WRREG);
          state_nxt = (op_q == OP_WRREG) ? ST_ACK : ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = sh_byte;
        if (tx_ready) begin
          sh_shift = 1'b1;
          if (sh_last) state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = rsp_q;
        if (tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 8'h00;
      rsp_q     <= 8'h00;
      addr_q    <= '0;
      addr_hi_q <= 1'b0;
      wdat_q    <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && rx_fire) begin
        op_q      <= rx_data;
        addr_hi_q <= 1'b0;
        rsp_q     <= RSP_ACK;
        if (rx_data == OP_HALT)        halted_q <= 1'b1;
        else if (rx_data == OP_RESUME) halted_q <= 1'b0;
        else if (rx_data != OP_RDREG && rx_data != OP_WRREG && rx_data != OP_RDCSR)
          rsp_q <= RSP_ERR;
      end
      if (state == ST_GET_ADDR && rx_fire) begin
        addr_hi_q <= 1'b1;
        if (!addr_hi_q) addr_q <= {4'b0000, rx_data};
        else            addr_q[11:8] <= rx_data[3:0];
      end
      // Write data only becomes visible once all bytes arrived, so an aborted write leaves it untouched.
      if (state == ST_GET_DATA && rx_fire && sh_last)
        wdat_q <= (sh_dat >> 8) | (N'(rx_data) << (N - 8));
    end
  end

  assign coprocessorIODataOut = wdat_q;
  assign halted               = halted_q;

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with a small core model (register file + one CSR).
module tb_debug_controller;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [14:0]  io_addr;
  logic [4:0]   io_ctrl;
  logic [N-1:0] io_dout;
  logic [N-1:0] io_din;
  logic         halted;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_pulses = 0;

  logic [63:0] regs [0:31];

  always #5 clk = ~clk;

  debug_controller #(.N(N)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .coprocessorIOAddr    (io_addr),
    .coprocessorIOControl (io_ctrl),
    .coprocessorIODataOut (io_dout),
    .coprocessorIODataIn  (io_din),
    .halted               (halted)
  );

  // Core model: combinational read, write on the clock edge of a write pulse.
  always_comb begin
    if (io_ctrl[3]) io_din = (io_addr[11:0] == 12'h300) ? 64'h0000_0000_0000_1808 : 64'h0;
    else            io_din = regs[io_addr[4:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (io_ctrl[0]) begin
      regs[io_addr[4:0]] <= io_dout;
    end
  end

  always @(posedge clk) if (io_ctrl[0]) wr_pulses <= wr_pulses + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rx_accept", {63'b0, rx_ready}, 64'd1);
    if (rx_ready) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int k;
    @(negedge clk);
    tx_ready = 1'b1;
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_vld"}, {63'b0, tx_valid}, 64'd1);
    chk(tag, {56'b0, tx_data}, {56'b0, exp});
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"},  {59'b0, io_ctrl}, 64'd0);
    chk({tag, "_addr"},  {49'b0, io_addr}, 64'd0);
    chk({tag, "_dout"},  io_dout, 64'd0);
    chk({tag, "_txv"},   {63'b0, tx_valid}, 64'd0);
    chk({tag, "_txd"},   {56'b0, tx_data}, 64'd0);
    chk({tag, "_rxr"},   {63'b0, rx_ready}, 64'd0);
    chk({tag, "_halt"},  {63'b0, halted}, 64'd0);
  endtask

  initial begin
    int pulses_before;
    logic [7:0] b;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", {63'b0, rx_ready}, 64'd1);

    // Halt / resume
    send_byte(8'h01);
    chk("halt_flag", {63'b0, halted}, 64'd1);
    chk("halt_ctrl", {59'b0, io_ctrl}, 64'b00100);
    expect_byte("halt_ack", 8'hAA);
    send_byte(8'h02);
    expect_byte("resume_ack", 8'hAA);
    chk("resume_ctrl", {59'b0, io_ctrl}, 64'd0);
    chk("resume_flag", {63'b0, halted}, 64'd0);
    send_byte(8'h01);
    expect_byte("halt2_ack", 8'hAA);

    // Register write: x5 = 0x1122334455667788, bytes LSB first
    send_byte(8'h11);
    send_byte(8'h05);
    for (int i = 0; i < 8; i++) begin
      b = 8'h88 - 8'(i * 8'h11);
      send_byte(b);
    end
    chk("wr_issue_ctrl", {59'b0, io_ctrl}, 64'b00111);
    chk("wr_issue_addr", {49'b0, io_addr}, 64'd5);
    chk("wr_issue_dout", io_dout, 64'h1122_3344_5566_7788);
    @(posedge clk);
    #1;
    chk("wr_sample_ctrl", {59'b0, io_ctrl}, 64'b00110);
    expect_byte("wr_ack", 8'hAA);
    chk("wr_pulse_count", 64'(wr_pulses), 64'd1);
    chk("wr_core_reg", regs[5], 64'h1122_3344_5566_7788);

    // Register read echoes the write
    send_byte(8'h10);
    send_byte(8'h05);
    chk("rd_issue_ctrl", {59'b0, io_ctrl}, 64'b00110);
    for (int i = 0; i < 8; i++) expect_byte("rd_byte", 8'h88 - 8'(i * 8'h11));

    // CSR read 0x300
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h03);
    chk("csr_issue_ctrl", {59'b0, io_ctrl}, 64'b01110);
    chk("csr_issue_addr", {49'b0, io_addr}, 64'h300);
    @(posedge clk);
    #1;
    chk("csr_sample_ctrl", {59'b0, io_ctrl}, 64'b01110);
    chk("csr_sample_addr", {49'b0, io_addr}, 64'h300);
    expect_byte("csr_b0", 8'h08);
    expect_byte("csr_b1", 8'h18);
    for (int i = 2; i < 8; i++) expect_byte("csr_bhi", 8'h00);

    // Unknown opcode
    send_byte(8'h7F);
    chk("err_ctrl", {59'b0, io_ctrl}, 64'b00100);
    expect_byte("err_rsp", 8'hEE);
    @(negedge clk);
    chk("err_idle_txv", {63'b0, tx_valid}, 64'd0);
    chk("err_idle_rxr", {63'b0, rx_ready}, 64'd1);

    // Backpressure on a register read response
    send_byte(8'h10);
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_txv", {63'b0, tx_valid}, 64'd1);
      chk("bp_txd", {56'b0, tx_data}, 64'h88);
      chk("bp_rxr", {63'b0, rx_ready}, 64'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) expect_byte("bp_byte", 8'h88 - 8'(i * 8'h11));
    @(negedge clk);
    chk("bp_done_txv", {63'b0, tx_valid}, 64'd0);

    // Access while running: core stalled only during ISSUE/SAMPLE
    send_byte(8'h02);
    expect_byte("resume2_ack", 8'hAA);
    send_byte(8'h10);
    send_byte(8'h05);
    chk("run_rd_ctrl", {59'b0, io_ctrl}, 64'b00010);
    for (int i = 0; i < 8; i++) expect_byte("run_rd_byte", 8'h88 - 8'(i * 8'h11));
    chk("run_after_ctrl", {59'b0, io_ctrl}, 64'd0);

    // Reset in the middle of a register write
    pulses_before = wr_pulses;
    send_byte(8'h11);
    send_byte(8'h07);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_rsp", {63'b0, tx_valid}, 64'd0);
    chk("midrst_no_pulse", 64'(wr_pulses), 64'(pulses_before));
    send_byte(8'h01);
    expect_byte("post_rst_ack", 8'hAA);
    chk("post_rst_halt", {63'b0, halted}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
Debug-side initiator of the datapath coprocessor IO port. It receives byte commands from a host link (valid/ready byte stream), halts and resumes the core, and reads or writes integer registers. It also reads CSRs. Responses go back as a byte stream. It sits between the host transport (UART/JTAG bridge) and the core's coprocessorIOAddr/Control/DataOut/DataIn pins. Any nonzero control value stalls the core's PC.

Parameters:
N, 64, core data width (register/CSR width); must be a multiple of 8
NB, N/8, data bytes per register transfer (derived, not overridable)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  command byte from host
rx_valid  in  1  rx_data valid
rx_ready  out  1  controller accepts rx_data this cycle
tx_data  out  8  response byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts tx_data this cycle
coprocessorIOAddr  out  15  [4:0] register index, [11:0] CSR address, [14:12] always 0
coprocessorIOControl  out  5  [0] register write, [1] access active, [2] halt, [3] CSR select, [4] reserved 0
coprocessorIODataOut  out  N  register write data to core
coprocessorIODataIn  in  N  register/CSR read data from core (combinational in core)
halted  out  1  core held by debug

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, halted=0. Core runs. Reset mid-command drops the command silently; no partial response.
- Byte handshake: transfer when valid&&ready on a rising clk edge. rx_ready=1 only in IDLE, GET_ADDR, GET_DATA. tx_data is stable while tx_valid=1 and tx_ready=0.
- Opcodes (first byte):
  - 0x01 HALT: set halted.
  - 0x02 RESUME: clear halted.
  - 0x10 RDREG: 1 addr byte, low 5 bits used.
  - 0x11 WRREG: 1 addr byte, then NB data bytes, little-endian.
  - 0x20 RDCSR: 2 addr bytes, little-endian, low 12 bits used.
  - other: error.
- Responses:
  - HALT, RESUME, WRREG: single ack byte 0xAA.
  - RDREG, RDCSR: NB bytes, little-endian.
  - unknown opcode: single 0xEE.
- FSM:
  - IDLE -> GET_ADDR (RD/WR ops) | ACK (HALT/RESUME/unknown).
  - GET_ADDR -> GET_DATA (WRREG) | ISSUE.
  - GET_DATA: 3-bit counter; after byte NB-1 -> ISSUE.
  - ISSUE: drive addr and control for exactly 1 cycle, -> SAMPLE.
  - SAMPLE: hold addr/control one more cycle; capture coprocessorIODataIn into shift register at end of cycle; -> SEND (reads) | ACK (write).
  - SEND: shift out NB bytes, LSB first -> IDLE.
  - ACK: 1 byte -> IDLE.
- Control encoding:
  - [2] = halted in every state.
  - ISSUE/SAMPLE: [1]=1; [3]=1 for RDCSR.
  - [0]=1 only in the ISSUE cycle of WRREG (single-cycle write pulse).
  - Outside ISSUE/SAMPLE: [1:0]=0, [3]=0.
- Access while not halted: still performed; the core stalls only for the ISSUE+SAMPLE cycles because control is nonzero, then runs again.
- Writes to register 0 are forwarded unchanged; the core ignores them.
- HALT when already halted and RESUME when running: idempotent, still ack 0xAA.
- coprocessorIODataOut is assembled from data bytes and held until the next WRREG; zero after reset.
- Latency: last command byte -> ISSUE next cycle -> first tx_valid 2 cycles later (SEND/ACK entry).

Decomposition:
- Package debug_pkg:
  - opcode constants (OP_HALT, OP_RESUME, OP_RDREG, OP_WRREG, OP_RDCSR).
  - response constants (RSP_ACK=8'hAA, RSP_ERR=8'hEE).
  - control bit index localparams.
  - state enum typedef.
- One natural sub-module: debug_byte_shifter. NB-byte little-endian shift register with load-parallel, shift-in and shift-out, and a byte counter. It is used both for assembling write data and for serialising read data.

Test Plan:
- After reset release: send 0x01.
  - Expect tx 0xAA, halted=1, coprocessorIOControl=5'b00100.
  - Send 0x02: expect 0xAA, control=0.
- Halted, send 0x11, 0x05, bytes 0x88,0x77,...,0x11.
  - Expect a single-cycle control=5'b00111 with addr=5 and DataOut=64'h1122334455667788, then 0xAA.
  - Follow with 0x10, 0x05: expect tx bytes 0x88..0x11 (core model echoes the register file).
- Send 0x20, 0x00, 0x03 with core model CSR 0x300 = 64'h0000_0000_0000_1808.
  - Expect control[3]=1 and addr[11:0]=12'h300 for 2 cycles, then tx 0x08,0x18,0x00 x6.
- Send 0x7F: expect tx 0xEE, no control activity, FSM back in IDLE; the next valid command still works.
- Hold tx_ready=0 for 10 cycles during a RDREG response.
  - tx_data/tx_valid stay stable, rx_ready=0; no bytes are lost once tx_ready rises.
- Assert reset low midway through the WRREG data bytes.
  - All outputs go to 0 immediately (async), no write pulse occurs, no response is sent.
  - After release, 0x01 is acked normally.
